// File: rtl/bcd_score_keeper_pkg.sv
// Shared game definitions for the BCD score keeper: FSM states, BCD constants and
// the combo-to-multiplier mapping.
package bcd_score_keeper_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StSub  = 2'd2
  } state_e;

  localparam logic [15:0] BCD_MAX16  = 16'h9999;
  localparam logic [15:0] BCD_ZERO16 = 16'h0000;
  localparam logic [7:0]  BCD_ZERO8  = 8'h00;
  localparam logic [7:0]  COMBO_MAX  = 8'h99;

  localparam logic [7:0] MULT_TH2 = 8'h10;
  localparam logic [7:0] MULT_TH3 = 8'h20;
  localparam logic [7:0] MULT_TH4 = 8'h30;

  // BCD preserves numeric ordering, so plain unsigned compares are valid here.
  function automatic logic [2:0] mult_of(input logic [7:0] combo);
    if (combo >= MULT_TH4) begin
      return 3'd4;
    end else if (combo >= MULT_TH3) begin
      return 3'd3;
    end else if (combo >= MULT_TH2) begin
      return 3'd2;
    end
    return 3'd1;
  endfunction

endpackage

// File: rtl/bcdaddsub4.sv
// Combinational 4-digit BCD adder/subtractor; result wraps modulo 10000, the caller
// detects overflow/underflow by comparing against the first operand.
module bcdaddsub4 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        op,
  output logic [15:0] s
);

  always_comb begin
    logic [3:0] w_ad;
    logic [3:0] w_bd;
    logic [4:0] w_t;
    logic       w_c;
    s   = '0;
    w_c = 1'b0;
    w_ad = '0;
    w_bd = '0;
    w_t  = '0;
    for (int i = 0; i < 4; i++) begin
      w_ad = a[4*i +: 4];
      w_bd = b[4*i +: 4];
      if (!op) begin
        w_t = {1'b0, w_ad} + {1'b0, w_bd} + {4'd0, w_c};
        w_c = (w_t > 5'd9);
        if (w_c) begin
          w_t = w_t - 5'd10;
        end
      end else begin
        // Bias by ten so the digit difference never goes negative; w_c is the borrow.
        w_t = {1'b0, w_ad} + 5'd10 - {1'b0, w_bd} - {4'd0, w_c};
        w_c = (w_t < 5'd10);
        if (!w_c) begin
          w_t = w_t - 5'd10;
        end
      end
      s[4*i +: 4] = w_t[3:0];
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// Saturating BCD score and combo keeper driving one shared BCD add/sub unit per cycle,
// with a one-entry pending slot for events that arrive while a sequence runs.
module bcd_score_keeper
  import bcd_score_keeper_pkg::*;
#(
  parameter logic [15:0] HIT_PTS  = 16'h0010,
  parameter logic [15:0] MISS_PTS = 16'h0005
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        restart,
  input  logic        hit,
  input  logic        miss,
  output logic [15:0] score,
  output logic [7:0]  combo,
  output logic [2:0]  mult,
  output logic        busy,
  output logic        drop
);

  state_e      r_state;
  logic [15:0] r_score;
  logic [7:0]  r_combo;
  logic [2:0]  r_cnt;
  logic        r_pend_vld;
  logic        r_pend_miss;
  logic        r_busy;
  logic        r_drop;

  logic        w_live_vld;
  logic        w_ev_vld;
  logic        w_ev_miss;
  logic [2:0]  w_mult;
  logic [7:0]  w_combo_inc;
  logic [15:0] w_b;
  logic        w_op;
  logic [15:0] w_sum;
  logic        w_add_ovf;
  logic        w_sub_unf;

  // A simultaneous hit and miss collapses into a miss.
  assign w_live_vld = hit | miss;
  assign w_ev_vld   = r_pend_vld | w_live_vld;
  assign w_ev_miss  = r_pend_vld ? r_pend_miss : miss;
  assign w_mult     = mult_of(r_combo);

  always_comb begin
    w_combo_inc = r_combo;
    if (r_combo != COMBO_MAX) begin
      if (r_combo[3:0] >= 4'd9) begin
        w_combo_inc = {r_combo[7:4] + 4'd1, 4'd0};
      end else begin
        w_combo_inc = {r_combo[7:4], r_combo[3:0] + 4'd1};
      end
    end
  end

  assign w_op = (r_state == StSub);
  assign w_b  = w_op ? MISS_PTS : HIT_PTS;

  bcdaddsub4 u_addsub (
    .a  (r_score),
    .b  (w_b),
    .op (w_op),
    .s  (w_sum)
  );

  assign w_add_ovf = (w_sum < r_score);
  assign w_sub_unf = (w_sum > r_score);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= StIdle;
      r_score     <= BCD_ZERO16;
      r_combo     <= BCD_ZERO8;
      r_cnt       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_miss <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
    end else if (restart) begin
      r_state     <= StIdle;
      r_score     <= BCD_ZERO16;
      r_combo     <= BCD_ZERO8;
      r_cnt       <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_miss <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_ev_vld) begin
            r_busy <= 1'b1;
            if (w_ev_miss) begin
              r_combo <= BCD_ZERO8;
              r_state <= StSub;
            end else begin
              r_cnt   <= w_mult;
              r_combo <= w_combo_inc;
              r_state <= StAdd;
            end
          end
          // The slot is freed as it is consumed, so a live event can refill it.
          if (r_pend_vld) begin
            r_pend_vld  <= w_live_vld;
            r_pend_miss <= miss;
          end
        end
        StAdd: begin
          r_score <= w_add_ovf ? BCD_MAX16 : w_sum;
          r_cnt   <= r_cnt - 3'd1;
          if (r_cnt <= 3'd1) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StSub: begin
          r_score <= w_sub_unf ? BCD_ZERO16 : w_sum;
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
      if (r_state != StIdle && w_live_vld) begin
        if (r_pend_vld) begin
          r_drop <= 1'b1;
        end else begin
          r_pend_vld  <= 1'b1;
          r_pend_miss <= miss;
        end
      end
    end
  end

  assign score = r_score;
  assign combo = r_combo;
  assign mult  = w_mult;
  assign busy  = r_busy;
  assign drop  = r_drop;

endmodule

// File: doc/bcd_score_keeper.md
# bcd_score_keeper

Sequential score accumulator for the gameplay datapath. Consumes per-note hit/miss events from the note-judging logic. Drives the shared 4-digit BCD add/subtract unit one operation per cycle to keep a saturating BCD score and a 2-digit BCD combo count. Score and combo feed the display/scoreboard stage directly.

## Interface
Parameters:
- HIT_PTS, 16'h0010: BCD points added per hit, per multiplier step. Must be valid BCD.
- MISS_PTS, 16'h0005: BCD points subtracted per miss. Must be valid BCD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- nrst  input  1  reset, asynchronous, active-low
- restart  input  1  synchronous clear of game state; highest priority
- hit  input  1  one-cycle pulse, note hit
- miss  input  1  one-cycle pulse, note missed
- score  output  16  registered BCD score, 0000–9999
- combo  output  8  registered BCD consecutive-hit count, 00–99
- mult  output  3  current multiplier (1–4), derived from combo
- busy  output  1  high while an ADD/SUB sequence is in progress
- drop  output  1  one-cycle pulse when an event is discarded

## Operation
- **Reset and restart.** nrst low, or restart at an edge, sets: score=0000, combo=00, pending slot empty, FSM=IDLE, drop=0. This gives busy=0 and mult=1.
- **Multiplier.** mult is combinational from combo:
  - combo 00–09 → 1
  - combo 10–19 → 2
  - combo 20–29 → 3
  - combo ≥30 → 4
- **Event selection.**
  - hit and miss asserted in the same cycle counts as a miss; the hit is ignored with no drop pulse.
  - In IDLE, a valid pending slot is consumed before the live input.
- **FSM states:** IDLE, ADD, SUB.
- **IDLE, accepting a hit:**
  - Latch iteration count = mult, computed from combo before the increment.
  - combo ← combo+1 in BCD, saturating at 99.
  - Go to ADD.
- **IDLE, accepting a miss:**
  - combo ← 00.
  - Go to SUB.
- **ADD:**
  - Each cycle: adder a=score, b=HIT_PTS, op=0; then score ← sum and the count decrements.
  - Overflow test: sum < score, compared as unsigned 16-bit (valid because BCD preserves ordering). On overflow, score ← 9999.
  - Once at 9999, remaining iterations hold 9999.
  - Return to IDLE after the last iteration.
- **SUB:**
  - One cycle: a=score, b=MISS_PTS, op=1.
  - Underflow test: result > score (with MISS_PTS ≠ 0). On underflow, score ← 0000.
  - Return to IDLE.
- **Pending slot** (one entry, holds the event type):
  - An event arriving while busy, or while IDLE is consuming pending, is stored if the slot is empty.
  - If the slot is full, the new event is discarded and drop pulses for one cycle.
- **Restart mid-sequence** aborts the sequence. Partial score updates are discarded because score clears.

## Timing
- A hit accepted at edge N, with mult=k:
  - busy is high for cycles N+1 … N+k.
  - score updates at edges N+1 … N+k.
  - combo shows its new value after edge N.
- A miss accepted at edge N: busy is high for one cycle; score is final after edge N+1.
- A pending event is accepted at the first IDLE edge after busy falls, so there are no idle bubbles beyond that IDLE cycle.
- drop is asserted in the cycle after the discarded event's edge.
- All outputs are registered except mult, which is combinational from the combo register.

## Structure
- Shared game package holds:
  - The FSM state enum.
  - BCD constants: BCD_MAX16 = 16'h9999, BCD_ZERO16, COMBO_MAX = 8'h99.
  - Multiplier threshold constants: 8'h10, 8'h20, 8'h30.
- One sub-module instance: bcdaddsub4, with a, b, op (0=add, 1=sub) and 16-bit BCD result s. It is purely combinational and is used once per cycle.
- The 2-digit BCD combo incrementer is local logic. Do not instantiate a second adder.

## Test plan
- After reset, pulse hit once → combo=01, busy high 1 cycle, score=0010.
- Preload combo=10 (ten hits, score=0100), then hit → mult=2, busy 2 cycles, score 0110 → 0120, combo=11.
- score=0003, pulse miss → score=0000 (clamped), combo=00, busy 1 cycle.
- score=9995, combo=30, hit → first iteration saturates to 9999, remaining 3 iterations hold 9999; combo=31.
- hit and miss in the same cycle at score=0050 → treated as a miss: score=0045, combo=00, drop=0.
- During a 4-iteration ADD, send hit (stored in pending), then miss (slot full) → drop pulses once; pending hit runs after IDLE. A restart asserted mid-run → score=0000, combo=00, busy=0 on the next edge.
